// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray conversions and
// the default address width. Functions are 16 bits wide; callers slice.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 9;

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  // Callers zero-extend a narrower Gray value, so the leading zeros
  // simply propagate down to the real MSB.
  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Plain flop chain bringing the Gray read pointer into the write domain.
// No logic between stages so each stage only ever sees one changing bit.
module sync_r2w #(
  parameter int W      = 10,
  parameter int STAGES = 2
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  // Shift the incoming pointer through the synchronizer stages
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer / full-flag controller of the async FIFO.
// All flags are computed from the post-write pointer and the synchronized
// read pointer, so they only ever lag a read (pessimistic), never a write.
// ADDRSIZE must be >= 2 and AFULL_SPACE in 1..DEPTH-1.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = ADDRSIZE_DEF,
  parameter int AFULL_SPACE = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wovf_clr,
  input  logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_SPACE);

  logic [PW-1:0] wbin, wbin_next, wgray_next;
  logic [PW-1:0] wq_rptr, wrbin, wlevel_next, full_cmp;
  logic          wen, wfull_next, wafull_next;

  sync_r2w #(.W(PW), .STAGES(SYNC_STAGES)) u_sync (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (rptr),
    .q      (wq_rptr)
  );

  // Next pointer and flag values; full means the write pointer is one lap
  // ahead, i.e. the two Gray MSBs differ from the read pointer's.
  always_comb begin
    wen         = winc & ~wfull;
    wbin_next   = wbin + PW'(wen);
    wgray_next  = PW'(bin2gray(16'(wbin_next)));
    wrbin       = PW'(gray2bin(16'(wq_rptr)));
    full_cmp    = {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]};
    wfull_next  = (wgray_next == full_cmp);
    wlevel_next = wbin_next - wrbin;
    wafull_next = (wlevel_next >= AFULL_LVL);
  end

  // Pointer, flag, level and sticky overflow registers
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      wptr         <= wgray_next;
      wfull        <= wfull_next;
      walmost_full <= wafull_next;
      wlevel       <= wlevel_next;
      if (winc && wfull)  woverflow <= 1'b1;
      else if (wovf_clr)  woverflow <= 1'b0;
    end
  end

  assign waddr = wbin[ADDRSIZE-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl with default parameters (ADDRSIZE=9).
module tb_wptr_full_ctrl;

  logic       wclk = 1'b0, wrst_n = 1'b0, winc = 1'b0, wovf_clr = 1'b0;
  logic [9:0] rptr = '0;
  logic [8:0] waddr;
  logic [9:0] wptr, wlevel;
  logic       wfull, walmost_full, woverflow;

  wptr_full_ctrl dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wovf_clr(wovf_clr),
    .rptr(rptr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  int edges = 0, errors = 0, checks = 0;
  always @(posedge wclk) edges <= edges + 1;

  localparam int F_WADDR = 0, F_WPTR = 1, F_WFULL = 2, F_WAF = 3, F_WLVL = 4, F_WOVF = 5;
  typedef struct { int cyc; int fid; int val; } exp_t;
  exp_t sb[$];

  function automatic int g(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic logic [31:0] actual(input int fid);
    case (fid)
      F_WADDR: return 32'(waddr);
      F_WPTR:  return 32'(wptr);
      F_WFULL: return 32'(wfull);
      F_WAF:   return 32'(walmost_full);
      F_WLVL:  return 32'(wlevel);
      default: return 32'(woverflow);
    endcase
  endfunction

  function automatic string fname(input int fid);
    case (fid)
      F_WADDR: return "waddr";
      F_WPTR:  return "wptr";
      F_WFULL: return "wfull";
      F_WAF:   return "walmost_full";
      F_WLVL:  return "wlevel";
      default: return "woverflow";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edges, act, exp);
    end
  endtask

  task automatic push(input int fid, input int val);
    exp_t e;
    e.cyc = edges; e.fid = fid; e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input int a, input int p, input int f, input int af,
                          input int l, input int o);
    push(F_WADDR, a); push(F_WPTR, p); push(F_WFULL, f);
    push(F_WAF, af);  push(F_WLVL, l); push(F_WOVF, o);
  endtask

  // Drive one cycle of inputs, return just after the edge
  task automatic step(input logic inc, input logic clr, input logic [9:0] rp);
    winc = inc; wovf_clr = clr; rptr = rp;
    @(posedge wclk); #1;
  endtask

  // Monitor: compare every expectation registered for the current edge
  always @(negedge wclk) begin
    while (sb.size() > 0 && sb[0].cyc <= edges) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < edges) chk({"stale_", fname(e.fid)}, 32'(e.cyc), edges);
      else chk(fname(e.fid), actual(e.fid), e.val);
    end
  end

  logic [9:0] prev;

  initial begin
    // Reset state
    repeat (2) @(posedge wclk); #1;
    push_all(0, 0, 0, 0, 0, 0);
    @(negedge wclk); wrst_n = 1'b1;

    // Fill from empty with rptr=0: full after 512, almost-full from 496
    for (int i = 1; i <= 512; i++) begin
      step(1'b1, 1'b0, 10'h000);
      push_all(i % 512, g(i), int'(i == 512), int'(i >= 496), i, 0);
    end

    // Writes while full: no movement, sticky overflow, set wins over clear
    step(1'b1, 1'b0, 10'h000); push_all(0, 'h300, 1, 1, 512, 1);
    step(1'b1, 1'b0, 10'h000); push_all(0, 'h300, 1, 1, 512, 1);
    step(1'b1, 1'b1, 10'h000); push(F_WOVF, 1);
    step(1'b0, 1'b1, 10'h000); push(F_WOVF, 0); push(F_WPTR, 'h300);
    step(1'b0, 1'b0, 10'h000); push(F_WOVF, 0);

    // One read seen: wfull drops on the third edge after rptr changes
    step(1'b0, 1'b0, 10'h001); push(F_WFULL, 1);
    step(1'b0, 1'b0, 10'h001); push(F_WFULL, 1); push(F_WLVL, 512);
    step(1'b0, 1'b0, 10'h001); push(F_WFULL, 0); push(F_WLVL, 511); push(F_WAF, 1);
    step(1'b1, 1'b0, 10'h001); push_all(1, 'h301, 1, 1, 512, 0);

    // Fresh start, burst to level 300, then async reset mid-burst
    winc = 1'b0; rptr = '0;
    @(negedge wclk); #1; wrst_n = 1'b0; #2; wrst_n = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b0, 10'h000);
      push(F_WADDR, i); push(F_WLVL, i);
    end
    @(negedge wclk); #1;
    wrst_n = 1'b0; #1;
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_walmost_full", 32'(walmost_full), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_woverflow", 32'(woverflow), 0);
    @(posedge wclk); #1;
    chk("rst_hold_waddr", 32'(waddr), 0);
    winc = 1'b0; wrst_n = 1'b1;
    push(F_WADDR, 0);

    // Streaming with rptr trailing: level settles at 7, wraps twice
    prev = '0;
    for (int n = 1; n <= 2100; n++) begin
      int r;
      r = (n > 5) ? n - 5 : 0;
      step(1'b1, 1'b0, 10'(g(r % 1024)));
      push_all(n % 512, g(n % 1024), 0, 0, (n < 7) ? n : 7, 0);
      chk("gray_hamming", 32'($countones(wptr ^ prev)), 1);
      prev = wptr;
    end

    step(1'b0, 1'b0, 10'(g(2095 % 1024)));
    step(1'b0, 1'b0, 10'(g(2095 % 1024)));
    chk("scoreboard_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and full-flag controller for the asynchronous FIFO. It sits directly upstream of the FIFO memory in the wclk domain and produces the memory write address and the full flag that gates memory writes. It also produces the Gray-coded write pointer that crosses to the read domain, synchronizes the read pointer coming back, and reports fill level, almost-full and a sticky overflow error.

## Interface
- ADDRSIZE, 9, memory address bits; DEPTH = 2**ADDRSIZE (power of two only)
- AFULL_SPACE, 16, walmost_full asserts when free slots <= AFULL_SPACE; legal range 1..DEPTH-1
- SYNC_STAGES, 2, flops in the rptr synchronizer; minimum 2
- wclk  in  1  write clock (the only clock)
- wrst_n  in  1  asynchronous, active-low reset
- winc  in  1  write request from producer
- wovf_clr  in  1  synchronous clear of woverflow
- rptr  in  ADDRSIZE+1  Gray read pointer from rclk domain (asynchronous to wclk)
- waddr  out  ADDRSIZE  memory write address (binary)
- wptr  out  ADDRSIZE+1  Gray write pointer to read domain, registered
- wfull  out  1  FIFO full, registered
- walmost_full  out  1  free slots <= AFULL_SPACE, registered
- wlevel  out  ADDRSIZE+1  occupied slots as seen from write domain, 0..DEPTH
- woverflow  out  1  sticky: winc seen while wfull

## Operation
- Pointers are ADDRSIZE+1 bits: wbin (binary) and wptr (Gray); waddr = wbin[ADDRSIZE-1:0].
- Accepted write: wen = winc & ~wfull. On wen, wbin_next = wbin+1 (mod 2**(ADDRSIZE+1)), wptr_next = bin2gray(wbin_next).
- rptr passes through a SYNC_STAGES flop chain to give wq_rptr; no logic between the chain's stages.
- Full: wfull_next = (wptr_next == {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]}).
- Level: wrbin = gray2bin(wq_rptr); wlevel_next = wbin_next - wrbin, ADDRSIZE+1 bits, modular subtraction; never exceeds DEPTH.
- walmost_full_next = (wlevel_next >= DEPTH - AFULL_SPACE).
- Overflow: winc & wfull sets woverflow next cycle; wovf_clr clears it; set wins over simultaneous clear. Rejected write changes no pointer.
- Flags are pessimistic: a read becomes visible only after synchronizer latency; wfull may stay high up to SYNC_STAGES+1 cycles after the read domain frees a slot. Never optimistic.
- Reset: wbin, wptr, synchronizer flops, wlevel = 0; wfull, walmost_full, woverflow = 0. Reset mid-burst discards the write pointer; the read domain must be reset concurrently (system rule, not checked here).

## Timing
- Write accepted on the wclk edge with winc=1 and wfull=0; waddr presents that slot's address in the same cycle (memory writes it on that edge).
- waddr, wptr, wlevel, wfull, walmost_full all update on the edge that accepts the write (one registered stage, zero extra latency).
- rptr change reaches wq_rptr after SYNC_STAGES edges; flags reflect it on the following edge.
- Wrap: wbin rolls 2**(ADDRSIZE+1)-1 -> 0; waddr rolls DEPTH-1 -> 0; Gray single-bit change on every increment, including wrap.
- winc held high while full: no pointer movement, woverflow=1 from the next cycle until cleared.

## Structure
- Package fifo_pkg: bin2gray and gray2bin functions (16-bit max width, callers slice); shared ADDRSIZE default.
- Sub-module sync_r2w: SYNC_STAGES-deep flop synchronizer, width ADDRSIZE+1, reset to 0 by wrst_n.
- Remaining logic (pointer, flags, level, overflow) flat in wptr_full_ctrl.

## Test plan
- Fill from reset, ADDRSIZE=9, rptr=0, winc=1 for 512 cycles -> waddr 0..511, wfull=1 after 512th write, wptr=0x300, wlevel=512.
- Continue winc=1 two more cycles while full -> waddr stays 0, wptr unchanged, woverflow=1; pulse wovf_clr -> woverflow=0 next cycle (with winc=0).
- Full, then drive rptr=bin2gray(1)=0x001 -> wfull drops exactly SYNC_STAGES+1 edges later, wlevel=511; one write refills -> wfull=1.
- AFULL_SPACE=16, rptr=0: after 495 writes walmost_full=0; after 496 writes walmost_full=1, wlevel=496.
- Wrap: stream with rptr tracking wptr (delayed 4 cycles) for 2100 writes -> wfull never asserts, waddr 511 -> 0 wrap, wptr Hamming distance 1 per increment, wbin wraps 1023 -> 0.
- Assert wrst_n=0 mid-burst at wlevel=300 -> all outputs 0 asynchronously, without waiting for wclk; after release first write uses waddr=0.
